// File: rtl/comm_master_param.sv
// comm_master_param: UART command master sending cmd + DATA_BYTES data frames, then awaiting a response byte or a timeout.
module comm_master_param #(
  parameter int DATA_BYTES   = 2,
  parameter int BAUD_DIV     = 2604,
  parameter int RESP_TIMEOUT = 1000000
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [7:0]                                    cmd,
  input  logic [8*((DATA_BYTES == 0) ? 1 : DATA_BYTES)-1:0] data,
  input  logic                                          send_cmd,
  input  logic                                          clr_resp_rdy,
  input  logic                                          RX,
  output logic                                          TX,
  output logic                                          busy,
  output logic                                          cmd_sent,
  output logic                                          resp_rdy,
  output logic [7:0]                                    resp,
  output logic                                          timeout
);
  localparam int DW = 8*((DATA_BYTES == 0) ? 1 : DATA_BYTES);
  localparam int BW = 8*(DATA_BYTES + 1);
  localparam int SH = DW - 8*DATA_BYTES;
  localparam logic [16:0] BD     = 17'(BAUD_DIV);
  localparam logic [15:0] HALF   = 16'(BAUD_DIV/2);
  localparam logic [15:0] BDM1   = 16'(BAUD_DIV-1);
  localparam logic [23:0] TO_END = 24'(RESP_TIMEOUT-1);
  localparam logic [2:0]  LAST   = 3'(DATA_BYTES);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WAIT_RESP} state_t;
  state_t r_state, w_next;
  logic [BW-1:0] r_buf;
  logic [9:0]    r_sh;
  logic [16:0]   r_baud;
  logic [3:0]    r_bit;
  logic [2:0]    r_idx;
  logic          r_tx, r_cmd_sent, r_timeout, r_resp_rdy;
  logic [7:0]    r_resp;
  logic [23:0]   r_to_cnt;
  logic          r_rx_s1, r_rx_s2, r_rx_d, r_rx_busy;
  logic [15:0]   r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic          w_accept, w_last, w_byte_end, w_rx_samp, w_rx_valid, w_to_hit;
  assign w_accept   = (r_state == IDLE) && send_cmd;
  assign w_last     = r_idx == LAST;
  // Non-final stop bits are one clock short in SHIFT because the LOAD cycle finishes them;
  // the final stop bit runs one clock long so cmd_sent lands after the full stop period.
  assign w_byte_end = (r_state == SHIFT) && (r_bit == 4'd9) && (r_baud == (w_last ? BD : BD - 17'd2));
  assign w_rx_samp  = r_rx_busy && (r_rx_cnt == HALF);
  assign w_rx_valid = w_rx_samp && (r_rx_bit == 4'd9) && r_rx_s2;
  assign w_to_hit   = (r_state == WAIT_RESP) && (r_to_cnt == TO_END);
  assign TX       = r_tx;
  assign busy     = r_state != IDLE;
  assign cmd_sent = r_cmd_sent;
  assign resp_rdy = r_resp_rdy;
  assign resp     = r_resp;
  assign timeout  = r_timeout;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (send_cmd) w_next = LOAD;
      LOAD:      w_next = SHIFT;
      SHIFT:     if (w_byte_end) w_next = w_last ? WAIT_RESP : LOAD;
      WAIT_RESP: if (w_rx_valid || w_to_hit) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx       <= 1'b1;
      r_buf      <= '0;
      r_sh       <= '0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_idx      <= '0;
      r_cmd_sent <= 1'b0;
      r_timeout  <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_tx <= (r_state == SHIFT) ? r_sh[0] : 1'b1;
      if (w_accept) begin
        r_buf <= BW'({cmd, data} >> SH);
        r_idx <= '0;
      end
      if (r_state == LOAD) begin
        r_sh   <= {1'b1, r_buf[BW-1 -: 8], 1'b0};
        r_buf  <= r_buf << 8;
        r_baud <= '0;
        r_bit  <= '0;
      end
      if (r_state == SHIFT) begin
        if (w_byte_end) r_idx <= w_last ? r_idx : r_idx + 3'd1;
        else if (r_bit != 4'd9 && r_baud == BD - 17'd1) begin
          r_baud <= '0;
          r_bit  <= r_bit + 4'd1;
          r_sh   <= {1'b1, r_sh[9:1]};
        end else r_baud <= r_baud + 17'd1;
      end
      r_cmd_sent <= w_accept ? 1'b0 : (w_byte_end && w_last) ? 1'b1 : r_cmd_sent;
      r_timeout  <= w_accept ? 1'b0 : (w_to_hit && !w_rx_valid) ? 1'b1 : r_timeout;
      r_to_cnt   <= (r_state != WAIT_RESP) ? '0 : (r_to_cnt == TO_END) ? r_to_cnt : r_to_cnt + 24'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b0;
      r_rx_s2    <= 1'b0;
      r_rx_d     <= 1'b0;
      r_rx_busy  <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_resp     <= '0;
      r_resp_rdy <= 1'b0;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      if (!r_rx_busy) begin
        r_rx_busy <= r_rx_d && !r_rx_s2;
        r_rx_cnt  <= '0;
        r_rx_bit  <= '0;
      end else begin
        r_rx_cnt <= (r_rx_cnt == BDM1) ? '0 : r_rx_cnt + 16'd1;
        r_rx_bit <= (r_rx_cnt == BDM1) ? r_rx_bit + 4'd1 : r_rx_bit;
        // A high start sample is a glitch; the stop sample always ends the frame.
        if (w_rx_samp && ((r_rx_bit == 4'd0 && r_rx_s2) || r_rx_bit == 4'd9)) r_rx_busy <= 1'b0;
        if (w_rx_samp && r_rx_bit != 4'd0 && r_rx_bit != 4'd9) r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
      end
      if (w_rx_valid) r_resp <= r_rx_sh;
      r_resp_rdy <= w_rx_valid ? 1'b1 : (clr_resp_rdy || w_accept) ? 1'b0 : r_resp_rdy;
    end
  end
endmodule

// File: tb/tb_comm_master_param.sv
// tb_comm_master_param: scoreboard bench for comm_master_param with a 2-data-byte and a 0-data-byte instance.
module tb_comm_master_param;
  localparam int BD = 16;
  logic clk = 0, rst_n = 0;
  logic [7:0] cmd0 = 0, cmd1 = 0, data1 = 0;
  logic [15:0] data0 = 0;
  logic send0 = 0, send1 = 0, clr0 = 0, clr1 = 0, rx0 = 1, rx1 = 1;
  logic tx0, busy0, cs0, rdy0, to0, tx1, busy1, cs1, rdy1, to1;
  logic [7:0] resp0, resp1;
  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  logic cap_tx[0:699], cap_cs[0:699], cap_to[0:699], cap_busy[0:699];

  comm_master_param #(.DATA_BYTES(2), .BAUD_DIV(BD), .RESP_TIMEOUT(5000)) u0 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd0), .data(data0), .send_cmd(send0), .clr_resp_rdy(clr0),
    .RX(rx0), .TX(tx0), .busy(busy0), .cmd_sent(cs0), .resp_rdy(rdy0), .resp(resp0), .timeout(to0));
  comm_master_param #(.DATA_BYTES(0), .BAUD_DIV(BD), .RESP_TIMEOUT(100)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd1), .data(data1), .send_cmd(send1), .clr_resp_rdy(clr1),
    .RX(rx1), .TX(tx1), .busy(busy1), .cmd_sent(cs1), .resp_rdy(rdy1), .resp(resp1), .timeout(to1));

  always #5 clk = ~clk;

  task automatic send_u0(input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    cmd0 = c; data0 = d; send0 = 1;
    exp_q.push_back(c); exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]);
    @(negedge clk);
    send0 = 0;
  endtask

  // cap_*[k] holds the value after the k-th rising edge following the send_cmd sample edge.
  task automatic capture_u0(input int n, input int inj_k, input int rst_k);
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      cap_tx[k] = tx0; cap_cs[k] = cs0; cap_busy[k] = busy0;
      send0 = (k == inj_k);
      if (k == inj_k) begin cmd0 = 8'hFF; data0 = 16'hFFFF; end
      if (k == rst_k) begin
        #3 rst_n = 0;
        #1;
        n_tests += 2;
        if (tx0 !== 1'b1) begin n_fail++; $display("FAIL async_rst_tx got=%b exp=1", tx0); end
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy got=%b exp=0", busy0); end
        break;
      end
    end
  endtask

  task automatic decode_frames(input int nf, input string tag);
    logic [9:0] fr;
    logic [7:0] e;
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < 10; b++) fr[b] = cap_tx[2 + 10*BD*f + BD*b + BD/2];
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL %s_sb_empty frame=%0d got=%h", tag, f, fr);
      end else begin
        e = exp_q.pop_front();
        if (fr !== {1'b1, e, 1'b0}) begin
          n_fail++; $display("FAIL %s_frame%0d got=%b exp=%b", tag, f, fr, {1'b1, e, 1'b0});
        end
      end
    end
  endtask

  task automatic rx_frame0(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx0 = f[i];
      repeat (BD-1) @(negedge clk);
    end
    @(negedge clk); rx0 = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests += 7;
    if (tx0 !== 1'b1) begin n_fail++; $display("FAIL rst_tx got=%b exp=1", tx0); end
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy0); end
    if (cs0 !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_sent got=%b exp=0", cs0); end
    if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL rst_resp_rdy got=%b exp=0", rdy0); end
    if (resp0 !== 8'h00) begin n_fail++; $display("FAIL rst_resp got=%h exp=00", resp0); end
    if (to0 !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got=%b exp=0", to0); end
    if (tx1 !== 1'b1) begin n_fail++; $display("FAIL rst_tx1 got=%b exp=1", tx1); end
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic;
    logic idle_ok;
    send_u0(8'h05, 16'hA5C3);
    capture_u0(600, -1, -1);
    idle_ok = 1;
    for (int k = 483; k < 600; k++) idle_ok &= (cap_tx[k] === 1'b1);
    n_tests += 6;
    if (cap_tx[1] !== 1'b1) begin n_fail++; $display("FAIL basic_tx_k1 got=%b exp=1", cap_tx[1]); end
    if (cap_tx[2] !== 1'b0) begin n_fail++; $display("FAIL basic_start_k2 got=%b exp=0", cap_tx[2]); end
    if (cap_busy[1] !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", cap_busy[1]); end
    if (cap_cs[481] !== 1'b0) begin n_fail++; $display("FAIL basic_cs_k481 got=%b exp=0", cap_cs[481]); end
    if (cap_cs[482] !== 1'b1) begin n_fail++; $display("FAIL basic_cs_k482 got=%b exp=1", cap_cs[482]); end
    if (!idle_ok) begin n_fail++; $display("FAIL basic_tx_idle_after got=0 exp=1"); end
    decode_frames(3, "basic");
  endtask

  task automatic test_loopback;
    rx_frame0(8'hA5, 1'b1);
    n_tests += 5;
    if (resp0 !== 8'hA5) begin n_fail++; $display("FAIL loop_resp got=%h exp=a5", resp0); end
    if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL loop_rdy got=%b exp=1", rdy0); end
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL loop_busy got=%b exp=0", busy0); end
    if (to0 !== 1'b0) begin n_fail++; $display("FAIL loop_timeout got=%b exp=0", to0); end
    @(negedge clk); clr0 = 1;
    @(negedge clk); clr0 = 0;
    if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL loop_clr got=%b exp=0", rdy0); end
  endtask

  task automatic test_ignore;
    send_u0(8'h11, 16'h1234);
    capture_u0(600, 100, -1);
    decode_frames(3, "ignore");
    n_tests += 3;
    if (cap_cs[482] !== 1'b1) begin n_fail++; $display("FAIL ignore_cs got=%b exp=1", cap_cs[482]); end
    rx_frame0(8'h3C, 1'b1);
    if (resp0 !== 8'h3C) begin n_fail++; $display("FAIL ignore_resp got=%h exp=3c", resp0); end
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL ignore_busy got=%b exp=0", busy0); end
  endtask

  task automatic test_glitch;
    @(negedge clk); clr0 = 1;
    @(negedge clk); clr0 = 0; rx0 = 0;
    repeat (3) @(negedge clk);
    rx0 = 1;
    repeat (40) @(negedge clk);
    n_tests += 5;
    if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL glitch_rdy got=%b exp=0", rdy0); end
    rx_frame0(8'h99, 1'b0);
    repeat (20) @(negedge clk);
    if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL badstop_rdy got=%b exp=0", rdy0); end
    if (resp0 !== 8'h3C) begin n_fail++; $display("FAIL badstop_resp got=%h exp=3c", resp0); end
    rx_frame0(8'h5E, 1'b1);
    if (resp0 !== 8'h5E) begin n_fail++; $display("FAIL recover_resp got=%h exp=5e", resp0); end
    if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL recover_rdy got=%b exp=1", rdy0); end
    @(negedge clk); clr0 = 1;
    @(negedge clk); clr0 = 0;
  endtask

  task automatic test_timeout;
    logic single;
    @(negedge clk); cmd1 = 8'h42; send1 = 1; exp_q.push_back(8'h42);
    @(negedge clk); send1 = 0;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      cap_tx[k] = tx1; cap_cs[k] = cs1; cap_to[k] = to1; cap_busy[k] = busy1;
    end
    single = 1;
    for (int k = 163; k < 300; k++) single &= (cap_tx[k] === 1'b1);
    n_tests += 8;
    if (cap_tx[2] !== 1'b0) begin n_fail++; $display("FAIL to_start got=%b exp=0", cap_tx[2]); end
    if (cap_cs[161] !== 1'b0) begin n_fail++; $display("FAIL to_cs_k161 got=%b exp=0", cap_cs[161]); end
    if (cap_cs[162] !== 1'b1) begin n_fail++; $display("FAIL to_cs_k162 got=%b exp=1", cap_cs[162]); end
    if (cap_to[261] !== 1'b0) begin n_fail++; $display("FAIL to_k261 got=%b exp=0", cap_to[261]); end
    if (cap_to[262] !== 1'b1) begin n_fail++; $display("FAIL to_k262 got=%b exp=1", cap_to[262]); end
    if (cap_busy[261] !== 1'b1) begin n_fail++; $display("FAIL to_busy_k261 got=%b exp=1", cap_busy[261]); end
    if (cap_busy[262] !== 1'b0) begin n_fail++; $display("FAIL to_busy_k262 got=%b exp=0", cap_busy[262]); end
    if (!single) begin n_fail++; $display("FAIL to_single_frame got=0 exp=1"); end
    decode_frames(1, "single");
  endtask

  task automatic test_reset_mid;
    logic idle_ok;
    send_u0(8'h5A, 16'h0F0F);
    capture_u0(600, -1, 2 + 20*BD + 40);
    decode_frames(2, "prerst");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    idle_ok = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      idle_ok &= (tx0 === 1'b1) && (busy0 === 1'b0);
    end
    n_tests += 3;
    if (!idle_ok) begin n_fail++; $display("FAIL postrst_idle got=0 exp=1"); end
    send_u0(8'h77, 16'hBEEF);
    capture_u0(600, -1, -1);
    if (cap_cs[482] !== 1'b1) begin n_fail++; $display("FAIL postrst_cs got=%b exp=1", cap_cs[482]); end
    decode_frames(3, "postrst");
    rx_frame0(8'hC3, 1'b1);
    if (resp0 !== 8'hC3) begin n_fail++; $display("FAIL postrst_resp got=%h exp=c3", resp0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_loopback;
    test_ignore;
    test_glitch;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
